// File: rtl/icache_responder.sv
// ============================================================================
// icache_responder: direct-mapped, one-word-per-line instruction cache that
// answers fetcher requests and refills misses from the memory read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_responder #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_able,
  input  logic        stall,
  input  logic        br_reset,
  output logic [31:0] ins_out,
  output logic        ins_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MISS  = 3'd1,
    RESP  = 3'd2,
    COOL  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           ins_out_q, ins_out_d;
  logic                  ins_ready_q, ins_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [INDEX_BITS-1:0] fill_idx_q, fill_idx_d;
  logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic                  fill_en;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  unused_pc_bits;

  assign req_idx        = fetch_pc[INDEX_BITS+1:2];
  assign req_tag        = fetch_pc[31:INDEX_BITS+2];
  assign hit            = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_pc_bits = ^fetch_pc[1:0];

  always_comb begin
    state_d     = state_q;
    ins_out_d   = ins_out_q;
    ins_ready_d = ins_ready_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_idx_d  = fill_idx_q;
    fill_tag_d  = fill_tag_q;
    fill_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (br_reset) begin
          ins_ready_d = 1'b0;
        end else if (fetch_able) begin
          fill_idx_d = req_idx;
          fill_tag_d = req_tag;
          if (hit) begin
            ins_out_d   = data_q[req_idx];
            ins_ready_d = 1'b1;
            state_d     = RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {fetch_pc[31:2], 2'b00};
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          fill_en   = 1'b1;
          if (br_reset) begin
            state_d = IDLE;
          end else begin
            ins_out_d   = mem_data;
            ins_ready_d = 1'b1;
            state_d     = RESP;
          end
        end else if (br_reset) begin
          // The memory transaction cannot be cancelled; drain it silently.
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (br_reset) begin
          ins_ready_d = 1'b0;
          state_d     = IDLE;
        end else if (!stall) begin
          ins_ready_d = 1'b0;
          state_d     = COOL;
        end
      end
      COOL: begin
        ins_ready_d = 1'b0;
        state_d     = IDLE;
      end
      DRAIN: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          fill_en   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = valid_q;
    if (fill_en) begin
      valid_d[fill_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      ins_out_q   <= 32'd0;
      ins_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      ins_out_q   <= ins_out_d;
      ins_ready_q <= ins_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fill_idx_q  <= fill_idx_d;
      fill_tag_q  <= fill_tag_d;
      valid_q     <= valid_d;
    end
  end

  // Tag/data arrays need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx_q]  <= fill_tag_q;
      data_q[fill_idx_q] <= mem_data;
    end
  end

  assign ins_out   = ins_out_q;
  assign ins_ready = ins_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// ============================================================================
// tb_icache_responder: directed self-checking bench for icache_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_able, stall, br_reset, mem_ready;
  logic [31:0] fetch_pc, mem_data;
  logic [31:0] ins_out, mem_addr;
  logic        ins_ready, mem_req;

  int n_checks = 0;
  int n_fail   = 0;

  icache_responder #(.INDEX_BITS(6)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .fetch_pc  (fetch_pc),
    .fetch_able(fetch_able),
    .stall     (stall),
    .br_reset  (br_reset),
    .ins_out   (ins_out),
    .ins_ready (ins_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; fetch_pc = 32'd0; fetch_able = 1'b0;
    stall = 1'b0; br_reset = 1'b0; mem_ready = 1'b0; mem_data = 32'd0;
    tick(); tick();
    n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ins_ready got=%b exp=0", ins_ready); end
    n_checks++; if (ins_out !== 32'd0) begin n_fail++; $display("FAIL reset_ins_out got=%h exp=0", ins_out); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss_and_hit();
    fetch_pc = 32'h0; fetch_able = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL cold_mem_req cyc=%0d got req=%b addr=%h exp req=1 addr=0", i, mem_req, mem_addr); end
      n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL cold_no_ready cyc=%0d got=%b exp=0", i, ins_ready); end
      if (i == 2) begin mem_ready = 1'b1; mem_data = 32'h0000_0013; end
      tick();
    end
    mem_ready = 1'b0; mem_data = 32'hDEAD_BEEF;
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h13) begin n_fail++; $display("FAIL cold_resp got rdy=%b ins=%h exp rdy=1 ins=00000013", ins_ready, ins_out); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_drop got=%b exp=0", mem_req); end
    tick();  // consumed -> COOL
    n_checks++; if (ins_ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_cool got rdy=%b req=%b exp 0 0", ins_ready, mem_req); end
    tick();  // COOL -> IDLE, no new request
    n_checks++; if (mem_req !== 1'b0 || ins_ready !== 1'b0) begin n_fail++; $display("FAIL cold_cool_idle got req=%b rdy=%b exp 0 0", mem_req, ins_ready); end
    tick();  // hit from IDLE
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h13) begin n_fail++; $display("FAIL hit_resp got rdy=%b ins=%h exp rdy=1 ins=00000013", ins_ready, ins_out); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_no_req got=%b exp=0", mem_req); end
    fetch_able = 1'b0;
    tick(); tick();
  endtask

  task automatic test_stall_hold();
    fetch_pc = 32'h0; fetch_able = 1'b1; stall = 1'b1;
    tick();
    fetch_able = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h13) begin n_fail++; $display("FAIL stall_hold cyc=%0d got rdy=%b ins=%h exp rdy=1 ins=00000013", i, ins_ready, ins_out); end
      if (i == 3) stall = 1'b0;
      tick();
    end
    n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%b exp=0", ins_ready); end
    tick();
  endtask

  task automatic test_alias_eviction();
    fetch_pc = 32'h100; fetch_able = 1'b1;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || ins_ready !== 1'b0) begin n_fail++; $display("FAIL alias_miss_100 got req=%b addr=%h rdy=%b exp 1 00000100 0", mem_req, mem_addr, ins_ready); end
    mem_ready = 1'b1; mem_data = 32'hAAAA_0100;
    tick();
    mem_ready = 1'b0; fetch_able = 1'b0;
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'hAAAA_0100) begin n_fail++; $display("FAIL alias_resp_100 got rdy=%b ins=%h exp 1 aaaa0100", ins_ready, ins_out); end
    tick(); tick();
    fetch_pc = 32'h0; fetch_able = 1'b1;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ins_ready !== 1'b0) begin n_fail++; $display("FAIL alias_remiss_0 got req=%b addr=%h rdy=%b exp 1 00000000 0", mem_req, mem_addr, ins_ready); end
    mem_ready = 1'b1; mem_data = 32'h0000_0013;
    tick();
    mem_ready = 1'b0; fetch_able = 1'b0;
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h13) begin n_fail++; $display("FAIL alias_refill_0 got rdy=%b ins=%h exp 1 00000013", ins_ready, ins_out); end
    tick(); tick();
  endtask

  task automatic test_flush_mid_miss();
    fetch_pc = 32'h40; fetch_able = 1'b1;
    tick();
    fetch_able = 1'b0;
    tick();
    br_reset = 1'b1;
    tick();
    br_reset = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || ins_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain got req=%b addr=%h rdy=%b exp 1 00000040 0", mem_req, mem_addr, ins_ready); end
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_req_held got=%b exp=1", mem_req); end
    mem_ready = 1'b1; mem_data = 32'h0050_0093;
    tick();
    mem_ready = 1'b0;
    n_checks++; if (mem_req !== 1'b0 || ins_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain_done got req=%b rdy=%b exp 0 0", mem_req, ins_ready); end
    tick();
    n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL flush_no_pulse got=%b exp=0", ins_ready); end
    fetch_able = 1'b1;
    tick();
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h0050_0093 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_later_hit got rdy=%b ins=%h req=%b exp 1 00500093 0", ins_ready, ins_out, mem_req); end
    fetch_able = 1'b0;
    tick(); tick();
  endtask

  task automatic test_flush_with_mem_ready();
    fetch_pc = 32'h80; fetch_able = 1'b1;
    tick();
    fetch_able = 1'b0; br_reset = 1'b1; mem_ready = 1'b1; mem_data = 32'h1234_5678;
    tick();
    br_reset = 1'b0; mem_ready = 1'b0;
    n_checks++; if (ins_ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_ready_same got rdy=%b req=%b exp 0 0", ins_ready, mem_req); end
    fetch_able = 1'b1;
    tick();
    n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h1234_5678 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_ready_fill_hit got rdy=%b ins=%h req=%b exp 1 12345678 0", ins_ready, ins_out, mem_req); end
    // Flush while the response is waiting for a stalled fetcher.
    fetch_able = 1'b0; stall = 1'b1; br_reset = 1'b1;
    tick();
    br_reset = 1'b0; stall = 1'b0;
    n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_resp got=%b exp=0", ins_ready); end
    tick();
  endtask

  task automatic test_rdy_low();
    fetch_pc = 32'h0; fetch_able = 1'b1;
    tick();
    fetch_able = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (ins_ready !== 1'b1 || ins_out !== 32'h13 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rdy_freeze cyc=%0d got rdy=%b ins=%h req=%b exp 1 00000013 0", i, ins_ready, ins_out, mem_req); end
    end
    rdy_in = 1'b1;
    tick();
    n_checks++; if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_consume got=%b exp=0", ins_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [4];
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b1;
    fetch_pc = 32'h0; fetch_able = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (ins_ready !== exp_rdy[i] || mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_spacing cyc=%0d got rdy=%b req=%b exp rdy=%b req=0", i, ins_ready, mem_req, exp_rdy[i]); end
    end
    fetch_able = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_stall_hold();
    test_alias_eviction();
    test_flush_mid_miss();
    test_flush_with_mem_ready();
    test_rdy_low();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder that serves fetch requests from the instruction fetcher.
- Direct-mapped, one 32-bit word per line, holding instructions indexed by PC.
- Hits answer after one cycle. Misses fetch the word from the memory controller, fill the line, then answer.
- Sits between the fetcher (request: pc plus fetch_able level; response: instruction plus ready level) and the memory controller's instruction read port.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS, tag width; tag = pc[31:INDEX_BITS+2].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous and active-high
- rdy_in  input  1  low = freeze all state and outputs
- fetch_pc  input  32  requested instruction address (word-aligned; pc[1:0] ignored)
- fetch_able  input  1  request level from fetcher; stays high while fetcher waits
- stall  input  1  fetcher cannot consume; response held while high
- br_reset  input  1  misprediction flush from ROB
- ins_out  output  32  instruction word
- ins_ready  output  1  ins_out valid; held until consumed
- mem_req  output  1  word read request to memory controller
- mem_addr  output  32  word address of read ({fetch_pc[31:2],2'b00})
- mem_ready  input  1  one-cycle pulse: mem_data valid, request done
- mem_data  input  32  returned word

Behaviour:
- Reset (rst_in=1 at posedge):
  - ins_out=0, ins_ready=0, mem_req=0, mem_addr=0.
  - All valid bits cleared; state=IDLE.
- Priority per posedge: rst_in > ~rdy_in (hold everything) > br_reset > normal operation.
- Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS]. Lookup is combinational on fetch_pc in IDLE.
- States: IDLE, MISS, RESP, COOL, DRAIN.
- IDLE:
  - fetch_able=0: stay.
  - fetch_able=1 and hit: ins_out<=data[idx], ins_ready<=1, latch request pc, go RESP. Hit latency is 1 cycle.
  - fetch_able=1 and miss: latch pc, mem_req<=1, mem_addr<=aligned pc, go MISS.
- MISS:
  - mem_req stays high until mem_ready.
  - On mem_ready: mem_req<=0; data/tag/valid of latched index <= mem_data/latched tag/1; ins_out<=mem_data; ins_ready<=1; go RESP. ins_ready rises the cycle after mem_ready.
  - fetch_pc/fetch_able changes are ignored while in MISS.
- RESP:
  - ins_ready held high, ins_out stable.
  - The response is consumed on the first cycle with stall=0; at that posedge ins_ready<=0 and go COOL.
- COOL:
  - One dead cycle; the request level is ignored (the fetcher still shows the old pc with fetch_able=1). Go IDLE.
  - Minimum back-to-back hit spacing is therefore 3 cycles.
- br_reset:
  - In IDLE/RESP/COOL: ins_ready<=0, go IDLE; no fill disturbed.
  - In MISS: ins_ready stays 0; go DRAIN and keep mem_req high (the controller transaction cannot be cancelled).
  - In DRAIN: no additional effect; stay DRAIN.
- DRAIN:
  - On mem_ready: mem_req<=0 and fill the line (the data is correct for its address), but do NOT assert ins_ready; go IDLE.
  - A request arriving during DRAIN waits until IDLE.
- Simultaneous mem_ready and br_reset in MISS: fill the line, ins_ready stays 0, go IDLE.
- Index aliasing: a fill overwrites the line unconditionally (no replacement policy). A hit requires valid && tag match.
- mem_addr holds its value after mem_req falls (don't-care); mem_req never asserts outside MISS/DRAIN.
- No write path; self-modifying code is unsupported.

Test Plan:
- Cold miss:
  - Stimulus: reset, fetch_pc=0x0, fetch_able=1; memory returns 0x00000013 with mem_ready 3 cycles after mem_req.
  - Required: mem_req=1 with mem_addr=0x0 the cycle after the request, held 3 cycles; ins_ready=1 with ins_out=0x13 the cycle after mem_ready; one COOL cycle with no new mem_req.
- Hit:
  - Stimulus: re-request pc 0x0 after the fill.
  - Required: ins_ready=1, ins_out=0x13 one cycle after acceptance; mem_req stays 0.
- Stall hold:
  - Stimulus: hit with stall=1 for 4 cycles.
  - Required: ins_ready/ins_out stable all 4 cycles; ins_ready drops at the posedge where stall=0.
- Alias eviction:
  - Stimulus: fill 0x0, then request 0x100 (same index for INDEX_BITS=6), then 0x0 again.
  - Required: 0x100 misses, and 0x0 misses again with mem_addr=0x0.
- Flush mid-miss:
  - Stimulus: br_reset one cycle after mem_req rises.
  - Required: mem_req held until mem_ready; no ins_ready pulse; a later request to the same pc hits.
- rdy_in low:
  - Stimulus: drop rdy_in during RESP for 2 cycles.
  - Required: all outputs frozen; normal consume afterwards.
